ysyx_23060208_clint: RTL and testbench
======================================

Name: ysyx_23060208_clint

Overview:
- AXI4-Lite-style responder on the EXU data-port protocol (aw/w/b/ar/r channels, same signal set and widths as the data SRAM port). It sits beside the data SRAM behind the EXU address decode.
- Provides a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register.
- Raises timer_irq while mtime >= mtimecmp.
- Gives software a cycle-accurate timebase plus the machine timer interrupt source.

Parameters:
- DATA_WIDTH, 32, bus data/address width
- BASE_ADDR, 32'h0200_0000, base of the register window; offset = addr - BASE_ADDR
- PRESCALE, 1, clk cycles per mtime increment (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- clint_awaddr  in  DATA_WIDTH  write address
- clint_awvalid  in  1  write address valid
- clint_awready  out  1  write address ready
- clint_wdata  in  DATA_WIDTH  write data
- clint_wstrb  in  3  store size: 3'b000 byte, 3'b001 half, 3'b010 word; others illegal
- clint_wvalid  in  1  write data valid
- clint_wready  out  1  write data ready
- clint_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- clint_bvalid  out  1  write response valid
- clint_bready  in  1  write response ready
- clint_araddr  in  DATA_WIDTH  read address
- clint_arvalid  in  1  read address valid
- clint_arready  out  1  read address ready
- clint_rdata  out  DATA_WIDTH  read data
- clint_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- clint_rvalid  out  1  read data valid
- clint_rready  in  1  read data ready
- timer_irq  out  1  level interrupt, mtime >= mtimecmp (unsigned 64-bit)

Behaviour:
- Register map (byte offsets): 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32]. Any other offset, or an unaligned address, gives SLVERR: reads return 0, writes are dropped.
- Reset (rst=0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale counter=0. awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, timer_irq=0.
- Counter:
  - A prescale counter counts 0..PRESCALE-1. mtime increments by 1 on the cycle it wraps; with PRESCALE=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
- Write FSM, states W_IDLE, W_RESP:
  - aw and w are accepted independently, in either order or the same cycle. Each ready drops after its handshake until the write completes; the captured address/data/size are latched.
  - Once both are captured, the register updates in that cycle's clock edge. bvalid rises the next cycle (state W_RESP).
  - bvalid/bresp hold until bready. On the handshake cycle: bvalid=0 next cycle, awready=wready=1 next cycle, back to W_IDLE.
  - Size: word writes all 32 bits. Half writes bits [15:0] or [31:16] per addr[1]; that address must be half-aligned. Byte writes the lane per addr[1:0]. Illegal size gives SLVERR with no update.
  - A write to mtime in the same cycle as an increment: the written value wins, and that increment is lost.
- Read FSM, states R_IDLE, R_RESP:
  - arready=1 in R_IDLE. On handshake, the addressed value is sampled from the live registers at that edge. Next cycle: rvalid=1, arready=0.
  - rdata/rresp hold stable until rready. After the handshake: rvalid=0 and arready=1 next cycle.
  - Minimum read latency: 1 cycle. Back-to-back reads are possible at one per 2 cycles.
- Read and write channels are fully independent and may be active simultaneously. A read hitting a register written in the same cycle returns the old value.
- timer_irq is a registered compare: updated each cycle from the post-update mtime/mtimecmp, so it shows 1 cycle after the condition.
- Reset asserted mid-transaction aborts everything: outstanding bvalid/rvalid drop immediately (async) and no register update completes.
- No combinational path from any input to any output.

Test Plan:
1. Reset release, PRESCALE=1, idle 10 cycles -> read 0x0 returns rdata=10 ±1 (check the exact cycle), rresp=00; read 0x4 returns 0; timer_irq=0.
2. Write mtimecmp lo=32'd50, hi=0 (aw one cycle before w on the first write, w before aw on the second) -> bvalid one cycle after both are captured, bresp=00. timer_irq rises one cycle after mtime reaches 50.
3. Write mtime lo=32'hFFFF_FFFE, hi=0 -> after 2 increments mtime=64'h1_0000_0000; read 0x4 returns 1.
4. Byte write 8'hAB to offset 0x9 (wstrb=000) with mtimecmp=64'hFFFF_FFFF_FFFF_FFFF -> read 0x8 returns 32'hFFFF_ABFF.
5. Read 0x10, write 0x3, write with wstrb=3'b011 -> SLVERR, rdata=0, no register change. Hold bready=0 for 5 cycles: bvalid and bresp stay stable and awready stays 0.
6. Issue a read and a write simultaneously, then assert rst mid-R_RESP -> both channels complete independently. On reset: rvalid/bvalid drop immediately, mtime=0, mtimecmp all-ones.

Source files
------------

// File: rtl/ysyx_23060208_clint.sv
// rtl/ysyx_23060208_clint.sv - machine timer (mtime/mtimecmp) responder on the EXU data-port bus
//
// Purpose: free-running 64-bit mtime with a prescaler, a 64-bit mtimecmp,
// and a registered level timer interrupt (mtime >= mtimecmp).
// Register window at BASE_ADDR: 0x0 mtime lo, 0x4 mtime hi, 0x8 mtimecmp lo, 0xC mtimecmp hi.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   clint_aw*/clint_w*/clint_b*    write address / data / response channels
//                                  (wstrb carries access size: 000 byte, 001 half, 010 word)
//   clint_ar*/clint_r*             read address / data channels
//   timer_irq                      level interrupt, registered compare
module ysyx_23060208_clint #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] clint_awaddr,
  input  logic                  clint_awvalid,
  output logic                  clint_awready,
  input  logic [DATA_WIDTH-1:0] clint_wdata,
  input  logic [2:0]            clint_wstrb,
  input  logic                  clint_wvalid,
  output logic                  clint_wready,
  output logic [1:0]            clint_bresp,
  output logic                  clint_bvalid,
  input  logic                  clint_bready,
  input  logic [DATA_WIDTH-1:0] clint_araddr,
  input  logic                  clint_arvalid,
  output logic                  clint_arready,
  output logic [DATA_WIDTH-1:0] clint_rdata,
  output logic [1:0]            clint_rresp,
  output logic                  clint_rvalid,
  input  logic                  clint_rready,
  output logic                  timer_irq
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0]    OKAY    = 2'b00;
  localparam logic [1:0]    SLVERR  = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [63:0]           mtime, mtime_n, mtimecmp, mtimecmp_n;
  logic [PW-1:0]         ps_cnt;
  logic                  tick;

  logic                  aw_got, w_got, aw_hs, w_hs, wr_fire, wr_ok;
  logic [DATA_WIDTH-1:0] aw_addr_q, w_data_q, wr_addr, wr_data, wr_off;
  logic [2:0]            w_size_q, wr_size;
  logic [31:0]           wr_old, wr_new;

  logic                  ar_hs, rd_ok;
  logic [DATA_WIDTH-1:0] rd_off;
  logic [31:0]           rd_val;

  assign tick = (ps_cnt == PS_LAST);

  // Handshakes derive from state only, so no input reaches an output combinationally.
  assign aw_hs = clint_awvalid && (w_state == W_IDLE) && !aw_got;
  assign w_hs  = clint_wvalid  && (w_state == W_IDLE) && !w_got;
  // Fire on the cycle the second half arrives (or both together), using the live bus value for it.
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr = aw_got ? aw_addr_q : clint_awaddr;
  assign wr_data = w_got  ? w_data_q  : clint_wdata;
  assign wr_size = w_got  ? w_size_q  : clint_wstrb;
  assign wr_off  = wr_addr - DATA_WIDTH'(BASE_ADDR);

  always_comb begin
    wr_ok = 1'b0;
    case (wr_off[3:2])
      2'd0:    wr_old = mtime[31:0];
      2'd1:    wr_old = mtime[63:32];
      2'd2:    wr_old = mtimecmp[31:0];
      default: wr_old = mtimecmp[63:32];
    endcase
    wr_new = wr_old;
    if (wr_off[DATA_WIDTH-1:4] == '0) begin
      case (wr_size)
        3'b000: begin
          wr_ok = 1'b1;
          case (wr_off[1:0])
            2'd0:    wr_new[7:0]   = wr_data[7:0];
            2'd1:    wr_new[15:8]  = wr_data[7:0];
            2'd2:    wr_new[23:16] = wr_data[7:0];
            default: wr_new[31:24] = wr_data[7:0];
          endcase
        end
        3'b001: if (!wr_off[0]) begin
          wr_ok = 1'b1;
          if (wr_off[1]) wr_new[31:16] = wr_data[15:0];
          else           wr_new[15:0]  = wr_data[15:0];
        end
        3'b010: if (wr_off[1:0] == 2'd0) begin
          wr_ok  = 1'b1;
          wr_new = wr_data[31:0];
        end
        default: ;
      endcase
    end
  end

  // A software write to mtime replaces the incremented value, dropping that tick.
  always_comb begin
    mtime_n    = mtime + {63'd0, tick};
    mtimecmp_n = mtimecmp;
    if (wr_fire && wr_ok) begin
      case (wr_off[3:2])
        2'd0:    mtime_n    = {mtime[63:32], wr_new};
        2'd1:    mtime_n    = {wr_new, mtime[31:0]};
        2'd2:    mtimecmp_n = {mtimecmp[63:32], wr_new};
        default: mtimecmp_n = {wr_new, mtimecmp[31:0]};
      endcase
    end
  end

  always_comb begin
    w_state_n     = w_state;
    clint_awready = 1'b0;
    clint_wready  = 1'b0;
    clint_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        clint_awready = !aw_got;
        clint_wready  = !w_got;
        if (wr_fire) w_state_n = W_RESP;
      end
      W_RESP: begin
        clint_bvalid = 1'b1;
        if (clint_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  assign ar_hs  = clint_arvalid && (r_state == R_IDLE);
  assign rd_off = clint_araddr - DATA_WIDTH'(BASE_ADDR);
  assign rd_ok  = (rd_off[DATA_WIDTH-1:4] == '0) && (rd_off[1:0] == 2'd0);

  always_comb begin
    rd_val = 32'd0;
    if (rd_ok) begin
      case (rd_off[3:2])
        2'd0:    rd_val = mtime[31:0];
        2'd1:    rd_val = mtime[63:32];
        2'd2:    rd_val = mtimecmp[31:0];
        default: rd_val = mtimecmp[63:32];
      endcase
    end
  end

  always_comb begin
    r_state_n     = r_state;
    clint_arready = 1'b0;
    clint_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        clint_arready = 1'b1;
        if (clint_arvalid) r_state_n = R_RESP;
      end
      R_RESP: begin
        clint_rvalid = 1'b1;
        if (clint_rready) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state     <= W_IDLE;
      r_state     <= R_IDLE;
      mtime       <= 64'd0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      ps_cnt      <= '0;
      timer_irq   <= 1'b0;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_size_q    <= 3'd0;
      clint_bresp <= OKAY;
      clint_rdata <= '0;
      clint_rresp <= OKAY;
    end else begin
      w_state   <= w_state_n;
      r_state   <= r_state_n;
      mtime     <= mtime_n;
      mtimecmp  <= mtimecmp_n;
      ps_cnt    <= tick ? '0 : ps_cnt + PW'(1);
      timer_irq <= (mtime >= mtimecmp);
      if (wr_fire) begin
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
        clint_bresp <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_got    <= 1'b1;
          aw_addr_q <= clint_awaddr;
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= clint_wdata;
          w_size_q <= clint_wstrb;
        end
      end
      if (ar_hs) begin
        clint_rdata <= DATA_WIDTH'(rd_val);
        clint_rresp <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// tb/tb_ysyx_23060208_clint.sv - directed self-checking bench for ysyx_23060208_clint
module tb_ysyx_23060208_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] clint_awaddr = '0;
  logic        clint_awvalid = 1'b0;
  logic        clint_awready;
  logic [31:0] clint_wdata = '0;
  logic [2:0]  clint_wstrb = '0;
  logic        clint_wvalid = 1'b0;
  logic        clint_wready;
  logic [1:0]  clint_bresp;
  logic        clint_bvalid;
  logic        clint_bready = 1'b0;
  logic [31:0] clint_araddr = '0;
  logic        clint_arvalid = 1'b0;
  logic        clint_arready;
  logic [31:0] clint_rdata;
  logic [1:0]  clint_rresp;
  logic        clint_rvalid;
  logic        clint_rready = 1'b0;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060208_clint dut (
    .clk(clk), .rst(rst),
    .clint_awaddr(clint_awaddr), .clint_awvalid(clint_awvalid), .clint_awready(clint_awready),
    .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb), .clint_wvalid(clint_wvalid),
    .clint_wready(clint_wready), .clint_bresp(clint_bresp), .clint_bvalid(clint_bvalid),
    .clint_bready(clint_bready), .clint_araddr(clint_araddr), .clint_arvalid(clint_arvalid),
    .clint_arready(clint_arready), .clint_rdata(clint_rdata), .clint_rresp(clint_rresp),
    .clint_rvalid(clint_rvalid), .clint_rready(clint_rready), .timer_irq(timer_irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] off, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    clint_araddr  = BASE + off;
    clint_arvalid = 1'b1;
    @(posedge clk); #1;
    clint_arvalid = 1'b0;
    chk({tag, "_rvalid"}, clint_rvalid, 1);
    chk({tag, "_arready"}, clint_arready, 0);
    chk({tag, "_rdata"}, clint_rdata, exp_data);
    chk({tag, "_rresp"}, clint_rresp, exp_resp);
    clint_rready = 1'b1;
    @(posedge clk); #1;
    clint_rready = 1'b0;
    chk({tag, "_rvalid_drop"}, clint_rvalid, 0);
    chk({tag, "_arready_back"}, clint_arready, 1);
  endtask

  // order: 0 aw and w together, 1 aw one cycle before w, 2 w one cycle before aw
  task automatic do_write(input logic [31:0] off, input logic [31:0] data, input logic [2:0] size,
                          input int order, input int hold, input logic [1:0] exp_resp,
                          input string tag);
    if (order == 1) begin
      clint_awaddr = BASE + off; clint_awvalid = 1'b1;
      @(posedge clk); #1;
      clint_awvalid = 1'b0;
      chk({tag, "_awready_low"}, clint_awready, 0);
      chk({tag, "_bvalid_early"}, clint_bvalid, 0);
    end else if (order == 2) begin
      clint_wdata = data; clint_wstrb = size; clint_wvalid = 1'b1;
      @(posedge clk); #1;
      clint_wvalid = 1'b0;
      chk({tag, "_wready_low"}, clint_wready, 0);
      chk({tag, "_bvalid_early"}, clint_bvalid, 0);
    end
    if (order != 1) begin clint_awaddr = BASE + off; clint_awvalid = 1'b1; end
    if (order != 2) begin clint_wdata = data; clint_wstrb = size; clint_wvalid = 1'b1; end
    @(posedge clk); #1;
    clint_awvalid = 1'b0;
    clint_wvalid  = 1'b0;
    chk({tag, "_bvalid"}, clint_bvalid, 1);
    chk({tag, "_bresp"}, clint_bresp, exp_resp);
    chk({tag, "_awready_busy"}, clint_awready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_bvalid"}, clint_bvalid, 1);
      chk({tag, "_hold_bresp"}, clint_bresp, exp_resp);
      chk({tag, "_hold_awready"}, clint_awready, 0);
    end
    clint_bready = 1'b1;
    @(posedge clk); #1;
    clint_bready = 1'b0;
    chk({tag, "_bvalid_drop"}, clint_bvalid, 0);
    chk({tag, "_awready_back"}, clint_awready, 1);
    chk({tag, "_wready_back"}, clint_wready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(posedge clk); #1;
    chk("rst_awready", clint_awready, 1);
    chk("rst_wready", clint_wready, 1);
    chk("rst_arready", clint_arready, 1);
    chk("rst_bvalid", clint_bvalid, 0);
    chk("rst_rvalid", clint_rvalid, 0);
    chk("rst_bresp", clint_bresp, 0);
    chk("rst_rresp", clint_rresp, 0);
    chk("rst_rdata", clint_rdata, 0);
    chk("rst_irq", timer_irq, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;

    // 1: ten increments after release, read samples mtime=10 at the handshake edge
    repeat (10) @(posedge clk); #1;
    do_read(32'h0, 32'd10, 2'b00, "t1_lo");
    do_read(32'h4, 32'd0, 2'b00, "t1_hi");
    chk("t1_irq", timer_irq, 0);

    // 2: mtimecmp = 50, then mtime = 40 -> irq rises one cycle after mtime reaches 50
    do_write(32'h8, 32'd50, 3'b010, 1, 0, 2'b00, "t2_cmp_lo");
    do_write(32'hC, 32'd0, 3'b010, 2, 0, 2'b00, "t2_cmp_hi");
    chk("t2_irq_before", timer_irq, 0);
    do_write(32'h0, 32'd40, 3'b010, 0, 0, 2'b00, "t2_mtime");
    repeat (9) @(posedge clk); #1;
    chk("t2_irq_at50", timer_irq, 0);
    @(posedge clk); #1;
    chk("t2_irq_rise", timer_irq, 1);

    // 3: carry from low to high word
    do_write(32'h4, 32'd0, 3'b010, 0, 0, 2'b00, "t3_hi");
    do_write(32'h0, 32'hFFFF_FFFE, 3'b010, 0, 0, 2'b00, "t3_lo");
    @(posedge clk); #1;
    do_read(32'h0, 32'd0, 2'b00, "t3_rd_lo");
    do_read(32'h4, 32'd1, 2'b00, "t3_rd_hi");
    chk("t3_irq", timer_irq, 1);

    // 4: byte and half sub-word writes into an all-ones mtimecmp
    do_write(32'h8, 32'hFFFF_FFFF, 3'b010, 0, 0, 2'b00, "t4_cmp_lo");
    do_write(32'hC, 32'hFFFF_FFFF, 3'b010, 0, 0, 2'b00, "t4_cmp_hi");
    chk("t4_irq_clear", timer_irq, 0);
    do_write(32'h9, 32'hABAB_ABAB, 3'b000, 0, 0, 2'b00, "t4_byte");
    do_read(32'h8, 32'hFFFF_ABFF, 2'b00, "t4_rd_byte");
    do_write(32'hE, 32'h1234_1234, 3'b001, 2, 0, 2'b00, "t4_half");
    do_read(32'hC, 32'h1234_FFFF, 2'b00, "t4_rd_half");

    // 5: error responses, no register change, stalled bready
    do_read(32'h10, 32'd0, 2'b10, "t5_rd_oor");
    do_write(32'h3, 32'd0, 3'b010, 0, 0, 2'b10, "t5_wr_unal");
    do_write(32'h8, 32'd0, 3'b011, 0, 5, 2'b10, "t5_wr_size");
    do_write(32'hB, 32'd0, 3'b010, 1, 0, 2'b10, "t5_wr_unal_b");
    do_write(32'hD, 32'd0, 3'b001, 0, 0, 2'b10, "t5_wr_half_odd");
    do_read(32'h8, 32'hFFFF_ABFF, 2'b00, "t5_rd_cmp_lo");
    do_read(32'hC, 32'h1234_FFFF, 2'b00, "t5_rd_cmp_hi");

    // 6: concurrent read/write to the same register returns the old value
    clint_araddr = BASE + 32'hC; clint_arvalid = 1'b1;
    clint_awaddr = BASE + 32'hC; clint_awvalid = 1'b1;
    clint_wdata = 32'd0; clint_wstrb = 3'b010; clint_wvalid = 1'b1;
    @(posedge clk); #1;
    clint_arvalid = 1'b0; clint_awvalid = 1'b0; clint_wvalid = 1'b0;
    chk("t6_rvalid", clint_rvalid, 1);
    chk("t6_bvalid", clint_bvalid, 1);
    chk("t6_rdata_old", clint_rdata, 32'h1234_FFFF);
    chk("t6_bresp", clint_bresp, 0);
    clint_rready = 1'b1; clint_bready = 1'b1;
    @(posedge clk); #1;
    clint_rready = 1'b0; clint_bready = 1'b0;
    chk("t6_rvalid_drop", clint_rvalid, 0);
    chk("t6_bvalid_drop", clint_bvalid, 0);
    do_read(32'hC, 32'd0, 2'b00, "t6_rd_new");

    // second concurrent pair left pending, then async reset mid-cycle
    clint_araddr = BASE + 32'h8; clint_arvalid = 1'b1;
    clint_awaddr = BASE + 32'h8; clint_awvalid = 1'b1;
    clint_wdata = 32'd5; clint_wstrb = 3'b010; clint_wvalid = 1'b1;
    @(posedge clk); #1;
    clint_arvalid = 1'b0; clint_awvalid = 1'b0; clint_wvalid = 1'b0;
    chk("t6b_rvalid", clint_rvalid, 1);
    chk("t6b_bvalid", clint_bvalid, 1);
    chk("t6b_rdata", clint_rdata, 32'hFFFF_ABFF);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_rvalid", clint_rvalid, 0);
    chk("t6_rst_bvalid", clint_bvalid, 0);
    chk("t6_rst_arready", clint_arready, 1);
    chk("t6_rst_awready", clint_awready, 1);
    chk("t6_rst_rdata", clint_rdata, 0);
    chk("t6_rst_irq", timer_irq, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    do_read(32'h0, 32'd0, 2'b00, "t6_mtime_lo");
    do_read(32'h4, 32'd0, 2'b00, "t6_mtime_hi");
    do_read(32'h8, 32'hFFFF_FFFF, 2'b00, "t6_cmp_lo");
    do_read(32'hC, 32'hFFFF_FFFF, 2'b00, "t6_cmp_hi");
    chk("t6_irq_after", timer_irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
